// File: rtl/block_dispatcher_pkg.sv
// Shared definitions for the block dispatcher and its round-robin picker.
// State codes are fixed so they read the same in waveforms across the array controllers.
package block_dispatcher_pkg;

  localparam int DEFAULT_INDEX_WIDTH = 4;
  localparam int MAX_NUM_PROC        = 16;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SELECT = 3'd1;
  localparam logic [2:0] ST_ISSUE  = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/block_dispatcher_rr_priority_picker.sv
// Combinational round-robin picker: first set bit of free at or above start, wrapping.
// Shared with the memory arbiter, so it knows nothing about dispatch state.
module rr_priority_picker
  import block_dispatcher_pkg::*;
#(
  parameter int num_proc = 4,
  localparam int pw = ptr_width(num_proc)
) (
  input  logic [num_proc-1:0] free,
  input  logic [pw-1:0]       start,
  output logic                found,
  output logic [num_proc-1:0] grant,
  output logic [pw-1:0]       grant_idx
);

  // Two passes: upper segment [start..n-1] has priority over the wrapped [0..start-1].
  always_comb begin
    found     = 1'b0;
    grant     = '0;
    grant_idx = '0;
    for (int p = 0; p < num_proc; p++) begin
      if (!found && free[p] && (p >= int'(start))) begin
        found     = 1'b1;
        grant[p]  = 1'b1;
        grant_idx = pw'(p);
      end
    end
    for (int p = 0; p < num_proc; p++) begin
      if (!found && free[p] && (p < int'(start))) begin
        found     = 1'b1;
        grant[p]  = 1'b1;
        grant_idx = pw'(p);
      end
    end
  end

endmodule

// File: rtl/block_dispatcher.sv
// Walks the mu x mu output-block grid row-major and hands each (i,j) to a free
// coprocessor over its ready/ack index port, then waits for all results.
module block_dispatcher
  import block_dispatcher_pkg::*;
#(
  parameter int num_proc    = 4,
  parameter int index_width = DEFAULT_INDEX_WIDTH,
  parameter int count_width = 2*index_width
) (
  input  logic                            in_clk,
  input  logic                            in_reset,
  input  logic                            in_start,
  input  logic [index_width-1:0]          in_mu,
  input  logic [num_proc-1:0]             in_index_ack,
  input  logic [num_proc-1:0]             in_result_ready,
  output logic [num_proc-1:0]             out_index_ready,
  output logic [num_proc*index_width-1:0] out_row_index,
  output logic [num_proc*index_width-1:0] out_col_index,
  output logic [index_width-1:0]          out_mu,
  output logic                            out_busy,
  output logic                            out_done,
  output logic [count_width-1:0]          out_issued
);

  localparam int pw = ptr_width(num_proc);

  logic [2:0]                               state, state_nxt;
  logic [index_width-1:0]                   mu_q, i_q, j_q, mu_last;
  logic [pw-1:0]                            p_q, rr_q, grant_idx;
  logic [num_proc-1:0]                      busy_mask, prev_res, rise, set_mask;
  logic [num_proc-1:0]                      ready_q, grant;
  logic [num_proc-1:0][index_width-1:0]     row_q, col_q;
  logic [count_width-1:0]                   issued_q, total;
  logic                                     found, start_acc, pick, ack_hit;
  logic                                     last_blk, run_done, busy_q, done_q;

  assign mu_last = mu_q - index_width'(1);
  assign total   = count_width'(mu_q) * count_width'(mu_q);
  assign rise    = in_result_ready & ~prev_res;

  rr_priority_picker #(.num_proc(num_proc)) u_picker (
    .free      (~busy_mask),
    .start     (rr_q),
    .found     (found),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: if (in_start) state_nxt = (in_mu == '0) ? ST_DONE : ST_SELECT;
      ST_SELECT:        if (found) state_nxt = ST_ISSUE;
      ST_ISSUE:         if (ack_hit) state_nxt = last_blk ? ST_DRAIN : ST_SELECT;
      ST_DRAIN:         if (busy_mask == '0) state_nxt = ST_DONE;
      default:          state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    start_acc = in_start && ((state == ST_IDLE) || (state == ST_DONE));
    pick      = (state == ST_SELECT) && found;
    ack_hit   = (state == ST_ISSUE) && in_index_ack[p_q];
    last_blk  = (i_q == mu_last) && (j_q == mu_last);
    run_done  = (state == ST_DRAIN) && (busy_mask == '0);
    set_mask  = '0;
    if (ack_hit) set_mask[p_q] = 1'b1;
  end

  // An ack and a result edge on the same processor leave it busy: the ack is the newer block.
  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      prev_res  <= '0;
      busy_mask <= '0;
      rr_q      <= '0;
      p_q       <= '0;
      mu_q      <= '0;
      i_q       <= '0;
      j_q       <= '0;
      ready_q   <= '0;
      row_q     <= '0;
      col_q     <= '0;
      issued_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      prev_res  <= in_result_ready;
      busy_mask <= (busy_mask & ~rise) | set_mask;
      if (start_acc) begin
        mu_q     <= in_mu;
        i_q      <= '0;
        j_q      <= '0;
        issued_q <= '0;
        busy_q   <= (in_mu != '0);
        done_q   <= (in_mu == '0);
      end
      if (pick) begin
        p_q              <= grant_idx;
        row_q[grant_idx] <= i_q;
        col_q[grant_idx] <= j_q;
        ready_q[grant_idx] <= 1'b1;
      end
      if (ack_hit) begin
        ready_q[p_q] <= 1'b0;
        rr_q         <= (p_q == pw'(num_proc-1)) ? '0 : p_q + 1'b1;
        if (issued_q != total) issued_q <= issued_q + 1'b1;
        if (last_blk) begin
          i_q <= '0;
          j_q <= '0;
        end else if (j_q == mu_last) begin
          j_q <= '0;
          i_q <= i_q + 1'b1;
        end else begin
          j_q <= j_q + 1'b1;
        end
      end
      if (run_done) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
    end
  end

  assign out_index_ready = ready_q;
  assign out_row_index   = row_q;
  assign out_col_index   = col_q;
  assign out_mu          = mu_q;
  assign out_busy        = busy_q;
  assign out_done        = done_q;
  assign out_issued      = issued_q;

endmodule

// File: tb/tb_block_dispatcher.sv
// Drives randomized processor behaviour into block_dispatcher and checks every cycle
// against a cycle-level model of the dispatch rules (row-major walk, round-robin, busy tracking).
module tb_block_dispatcher;

  localparam int N  = 4;
  localparam int IW = 4;
  localparam int CW = 8;
  localparam int PW = 2;

  logic            clk = 1'b0;
  logic            rst, start;
  logic [IW-1:0]   mu;
  logic [N-1:0]    ack, res;
  logic [N-1:0]    ready;
  logic [N*IW-1:0] row, col;
  logic [IW-1:0]   mu_o;
  logic            busy, done;
  logic [CW-1:0]   issued;

  always #5 clk = ~clk;

  block_dispatcher #(.num_proc(N), .index_width(IW), .count_width(CW)) dut (
    .in_clk          (clk),
    .in_reset        (rst),
    .in_start        (start),
    .in_mu           (mu),
    .in_index_ack    (ack),
    .in_result_ready (res),
    .out_index_ready (ready),
    .out_row_index   (row),
    .out_col_index   (col),
    .out_mu          (mu_o),
    .out_busy        (busy),
    .out_done        (done),
    .out_issued      (issued)
  );

  int vectors = 0;
  int miscompares = 0;

  // reference model
  logic [N-1:0]  busy_m, prev_m;
  logic [PW-1:0] rr_m, pend_p;
  int            i_m, j_m, issued_m, mu_m;
  bit            running_m, done_m, sel_m, pend, pick_now, just_acked;
  int            row_m[N], col_m[N];

  // processor emulation
  int ack_dly[N], res_dly[N], res_hold[N];
  int ack_mode, res_lo, res_hi;
  bit sc_mode;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    busy_m = '0; prev_m = '0; rr_m = '0; pend_p = '0;
    i_m = 0; j_m = 0; issued_m = 0; mu_m = 0;
    running_m = 0; done_m = 0; sel_m = 0; pend = 0; pick_now = 0; just_acked = 0;
    for (int k = 0; k < N; k++) begin
      logic [PW-1:0] pk;
      pk = PW'(k);
      row_m[pk] = 0; col_m[pk] = 0;
      ack_dly[pk] = 0; res_dly[pk] = 0; res_hold[pk] = 0;
    end
  endtask

  task automatic tick();
    logic [N-1:0]    bb, rise, setm, oh;
    logic [N*IW-1:0] er, ec;
    logic [PW-1:0]   q;
    bit              idle_b, fin_b, got;
    string           tag;
    @(posedge clk);
    bb     = busy_m;
    idle_b = !running_m;
    fin_b  = running_m && (issued_m == mu_m*mu_m);
    rise   = res & ~prev_m;
    prev_m = res;
    setm   = '0;
    pick_now = 0; just_acked = 0;
    // a waiting SELECT takes the first processor free during the previous cycle, from rr upward
    if (sel_m && (bb != '1)) begin
      got = 0; q = '0;
      for (int k = 0; k < N; k++) begin
        logic [PW-1:0] c;
        c = PW'((int'(rr_m) + k) % N);
        if (!got && !bb[c]) begin got = 1; q = c; end
      end
      pick_now = 1; sel_m = 0; pend = 1; pend_p = q;
      row_m[q] = i_m; col_m[q] = j_m;
      ack_dly[q] = (ack_mode < 0) ? int'($urandom_range(0, 3)) : ack_mode;
    end else if (pend && ack[pend_p]) begin
      setm[pend_p] = 1'b1; pend = 0; just_acked = 1;
      issued_m++;
      rr_m = PW'((int'(pend_p) + 1) % N);
      res_dly[pend_p] = (sc_mode && pend_p == PW'(1)) ? 16 : int'($urandom_range(res_lo, res_hi));
      if (issued_m != mu_m*mu_m) begin
        sel_m = 1;
        j_m++;
        if (j_m == mu_m) begin j_m = 0; i_m++; end
      end
    end
    busy_m = (busy_m & ~rise) | setm;
    if (fin_b && bb == '0) begin done_m = 1; running_m = 0; end
    if (start && idle_b) begin
      mu_m = int'(mu); i_m = 0; j_m = 0; issued_m = 0;
      if (mu == '0) begin done_m = 1; running_m = 0; end
      else begin done_m = 0; running_m = 1; sel_m = 1; end
    end

    @(negedge clk);
    chk("issued", 64'(issued), 64'(issued_m));
    chk("busy", 64'(busy), 64'(running_m));
    chk("done", 64'(done), 64'(done_m));
    chk("mu", 64'(mu_o), 64'(mu_m));
    oh = '0;
    if (pend) begin
      oh[pend_p] = 1'b1;
      tag = pick_now ? "pick" : "hold";
    end else begin
      tag = just_acked ? "drop" : "no_ready";
    end
    chk(tag, 64'(ready), 64'(oh));
    er = '0; ec = '0;
    for (int k = 0; k < N; k++) begin
      logic [PW-1:0] pk;
      pk = PW'(k);
      er = er | ((N*IW)'(row_m[pk]) << (k*IW));
      ec = ec | ((N*IW)'(col_m[pk]) << (k*IW));
    end
    chk("row", 64'(row), 64'(er));
    chk("col", 64'(col), 64'(ec));

    // processor responses for the next edge
    for (int k = 0; k < N; k++) begin
      logic [PW-1:0] pk;
      pk = PW'(k);
      ack[pk] = 1'b0;
      if (res_hold[pk] > 0) begin
        res_hold[pk]--;
        if (res_hold[pk] == 0) res[pk] = 1'b0;
      end else if (res_dly[pk] > 0) begin
        res_dly[pk]--;
        if (res_dly[pk] == 0) begin res[pk] = 1'b1; res_hold[pk] = 1; end
      end
      if (pend && pend_p == pk) begin
        if (ack_dly[pk] == 0) begin
          ack[pk] = 1'b1;
          if (sc_mode && pk == PW'(1)) begin res[pk] = 1'b1; res_hold[pk] = 12; end
        end else begin
          ack_dly[pk]--;
        end
      end
    end
    mu = IW'($urandom_range(0, 15));
  endtask

  task automatic run(input int m, input int am, input int rlo, input int rhi,
                     input bit sc, input int inj);
    ack_mode = am; res_lo = rlo; res_hi = rhi; sc_mode = sc;
    mu = IW'(m); start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 4000 && !done_m; c++) begin
      if (c == inj && running_m) start = 1'b1;
      tick();
      start = 1'b0;
    end
    chk("run_done", 64'(done), 64'(1));
    chk("run_issued", 64'(issued), 64'(m*m));
    repeat (3) tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mu = '0; ack = '0; res = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(ready), 64'(0));
    chk("rst_row", 64'(row), 64'(0));
    chk("rst_col", 64'(col), 64'(0));
    chk("rst_mu", 64'(mu_o), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_issued", 64'(issued), 64'(0));
    rst = 1'b0;

    run(2, 0, 10, 10, 0, -1);
    run(3, 0, 20, 20, 0, -1);
    run(0, 0, 1, 1, 0, -1);
    run(2, 5, 3, 8, 0, -1);
    run(2, 0, 3, 8, 1, -1);
    for (int r = 0; r < 4; r++)
      run(int'($urandom_range(1, 5)), -1, 1, 15, 0, int'($urandom_range(2, 10)));
    run(15, -1, 1, 6, 0, 20);

    // reset while an index is waiting for its ack
    ack_mode = 8; res_lo = 3; res_hi = 6; sc_mode = 0;
    mu = IW'(4); start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 50 && !pend; c++) tick();
    chk("pre_rst_ready", 64'(ready != '0), 64'(1));
    #2 rst = 1'b1;
    #1;
    chk("arst_ready", 64'(ready), 64'(0));
    chk("arst_row", 64'(row), 64'(0));
    chk("arst_col", 64'(col), 64'(0));
    chk("arst_mu", 64'(mu_o), 64'(0));
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_done", 64'(done), 64'(0));
    chk("arst_issued", 64'(issued), 64'(0));
    ack = '0; res = '0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    run(1, 0, 2, 5, 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
